mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 190 +++++++++++++++++++
 tb/tb_mdu.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO pair.
// mult/multu/div/divu compute their result at the accepting edge, hold it in a
// pending register for a fixed busy period, then retire it into HI/LO.
// mthi/mtlo write HI/LO directly in a single cycle without going busy.
//
// Handshake: a request is taken on a rising edge where start=1, the unit is
// IDLE, reset=0 and md_op is not reserved. There is no ready output; the
// pipeline must hold off new requests while busy=1, and any start seen while
// BUSY (including the retiring edge) is dropped.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data,
  output logic        o_dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Counter load values: the counter expires after reaching zero, so load N-1
  // to get exactly N busy cycles.
  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_res_wr;

  logic        w_op_legal;
  logic        w_is_mult;
  logic        w_is_div;
  logic        w_accept;
  logic        w_retire;

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_safe_b;
  logic [31:0] w_mag_q;
  logic [31:0] w_mag_r;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Opcode decode
  assign w_is_mult  = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign w_is_div   = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign w_op_legal = (md_op != 3'b110) && (md_op != 3'b111);

  // 64-bit products; sign/zero-extend to 64 bits so the low 64 bits of the
  // product are exact for both interpretations.
  assign w_prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
  assign w_prod_u = {32'b0, rs_data} * {32'b0, rt_data};

  // Division on magnitudes, then sign correction: quotient negative when the
  // operand signs differ (truncation toward zero), remainder follows the
  // dividend. 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
  assign w_div_signed = (md_op == OP_DIV);
  assign w_neg_a      = w_div_signed & rs_data[31];
  assign w_neg_b      = w_div_signed & rt_data[31];
  assign w_mag_a      = w_neg_a ? (32'd0 - rs_data) : rs_data;
  assign w_mag_b      = w_neg_b ? (32'd0 - rt_data) : rt_data;
  // A zero divisor never retires; substitute 1 so the divider stays defined.
  assign w_safe_b     = (rt_data == 32'd0) ? 32'd1 : w_mag_b;
  assign w_mag_q      = w_mag_a / w_safe_b;
  assign w_mag_r      = w_mag_a % w_safe_b;
  assign w_quo        = (w_neg_a ^ w_neg_b) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_rem        = w_neg_a ? (32'd0 - w_mag_r) : w_mag_r;

  // Next-state logic: accept only in IDLE, retire when the counter expires
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_op_legal) begin
          w_accept = 1'b1;
          if (w_is_mult || w_is_div) begin
            w_next_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (r_cnt == 5'd0) begin
          w_retire     = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register, busy flag and busy-period counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_BUSY);
      if (w_accept && w_is_mult) begin
        r_cnt <= MULT_LOAD;
      end else if (w_accept && w_is_div) begin
        r_cnt <= DIV_LOAD;
      end else if (r_state == S_BUSY && r_cnt != 5'd0) begin
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  // Pending result capture and architectural HI/LO updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_res_wr <= 1'b0;
    end else begin
      if (w_accept) begin
        case (md_op)
          OP_MULT: begin
            r_res_hi <= w_prod_s[63:32];
            r_res_lo <= w_prod_s[31:0];
            r_res_wr <= 1'b1;
          end
          OP_MULTU: begin
            r_res_hi <= w_prod_u[63:32];
            r_res_lo <= w_prod_u[31:0];
            r_res_wr <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            r_res_hi <= w_rem;
            r_res_lo <= w_quo;
            r_res_wr <= (rt_data != 32'd0);
          end
          OP_MTHI: r_hi <= rs_data;
          OP_MTLO: r_lo <= rs_data;
          default: begin
          end
        endcase
      end
      if (w_retire && r_res_wr) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end
  end

  assign busy        = r_busy;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign rd_data     = rd_sel ? r_hi : r_lo;
  assign o_dbg_state = (r_state == S_BUSY);

endmodule

// File: tb/tb_mdu.sv
// Directed + randomized bench for mdu against an arithmetic model of HI/LO.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] exp_q[$];

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .md_op      (md_op),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .rd_sel     (rd_sel),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .rd_data    (rd_data),
    .o_dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Reference model: new {hi,lo} after an accepted op
  function automatic logic [63:0] ref_op(logic [2:0] op, logic [31:0] a,
                                         logic [31:0] b, logic [31:0] oh,
                                         logic [31:0] ol);
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    logic [63:0] r;
    r = {oh, ol};
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        r  = sp;
      end
      3'd1: begin
        up = {32'b0, a};
        r  = up * {32'b0, b};
      end
      3'd2: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        r  = {sr[31:0], sq[31:0]};
      end
      3'd3: if (b != 0) r = {a % b, a / b};
      3'd4: r = {a, ol};
      3'd5: r = {oh, a};
      default: r = {oh, ol};
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    tick();
    start   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
  endtask

  // Check hi/lo and both rd_sel views against the model
  task automatic check_regs(input string tag);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
    rd_sel = 1'b1;
    #1;
    check({tag, "_rd_hi"}, rd_data, m_hi);
    rd_sel = 1'b0;
    #1;
    check({tag, "_rd_lo"}, rd_data, m_lo);
  endtask

  // Full mult/div transaction with per-cycle busy and hold checks
  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int          n;
    logic [63:0] e;
    n = (op < 3'd2) ? MC : DC;
    exp_q.push_back(ref_op(op, a, b, m_hi, m_lo));
    issue(op, a, b);
    for (int j = 1; j <= n; j++) begin
      check($sformatf("%s_busy_c%0d", tag, j), {31'b0, busy}, 32'd1);
      check($sformatf("%s_hold_hi_c%0d", tag, j), hi, m_hi);
      check($sformatf("%s_hold_lo_c%0d", tag, j), lo, m_lo);
      tick();
    end
    e    = exp_q.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    check({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
    check_regs({tag, "_done"});
  endtask

  task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
    logic [63:0] e;
    e = ref_op(op, a, 32'd0, m_hi, m_lo);
    issue(op, a, 32'd0);
    m_hi = e[63:32];
    m_lo = e[31:0];
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_regs(tag);
  endtask

  initial begin
    logic [63:0] e;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    reset   = 1'b1;
    start   = 1'b0;
    md_op   = 3'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    rd_sel  = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("reset_busy", {31'b0, busy}, 32'd0);
    check_regs("reset");

    // Signed and unsigned multiply of -2 x 3
    run_md("mult", 3'd0, 32'hFFFFFFFE, 32'h00000003);
    check("mult_const_hi", hi, 32'hFFFFFFFF);
    check("mult_const_lo", lo, 32'hFFFFFFFA);
    run_md("multu", 3'd1, 32'hFFFFFFFE, 32'h00000003);
    check("multu_const_hi", hi, 32'h00000002);
    check("multu_const_lo", lo, 32'hFFFFFFFA);

    // Signed and unsigned divide
    run_md("div", 3'd2, 32'hFFFFFFF9, 32'h00000002);
    check("div_const_lo", lo, 32'hFFFFFFFD);
    check("div_const_hi", hi, 32'hFFFFFFFF);
    run_md("divu", 3'd3, 32'd7, 32'd2);
    check("divu_const_lo", lo, 32'd3);
    check("divu_const_hi", hi, 32'd1);

    // Back-to-back mthi / mtlo
    run_mt("mthi", 3'd4, 32'h12345678);
    run_mt("mtlo", 3'd5, 32'h9ABCDEF0);
    check("mtx_const_hi", hi, 32'h12345678);
    check("mtx_const_lo", lo, 32'h9ABCDEF0);

    // Divide by zero leaves HI/LO untouched after the full busy period
    run_mt("mtlo55", 3'd5, 32'h00000055);
    run_md("divu_zero", 3'd3, 32'h00001234, 32'd0);
    check("divu_zero_const_lo", lo, 32'h00000055);
    run_md("div_zero", 3'd2, 32'hFFFF0000, 32'd0);

    // Signed overflow case
    run_md("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_const_lo", lo, 32'h80000000);
    check("div_ovf_const_hi", hi, 32'h00000000);

    // Reserved opcodes change nothing
    run_mt("mthi_pre", 3'd4, 32'hA5A5A5A5);
    issue(3'd6, 32'hDEADBEEF, 32'h1);
    check("rsv6_busy", {31'b0, busy}, 32'd0);
    check_regs("rsv6");
    issue(3'd7, 32'hDEADBEEF, 32'h1);
    check("rsv7_busy", {31'b0, busy}, 32'd0);
    tick();
    check("rsv7_busy_later", {31'b0, busy}, 32'd0);
    check_regs("rsv7");

    // Start while busy is ignored; original result retires on schedule
    e = ref_op(3'd0, 32'h00010001, 32'h00020003, m_hi, m_lo);
    issue(3'd0, 32'h00010001, 32'h00020003);
    for (int j = 1; j <= MC; j++) begin
      check($sformatf("ign_busy_c%0d", j), {31'b0, busy}, 32'd1);
      check($sformatf("ign_hold_hi_c%0d", j), hi, m_hi);
      if (j == 2) begin
        start   = 1'b1;
        md_op   = 3'd2;
        rs_data = 32'd100;
        rt_data = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    m_hi  = e[63:32];
    m_lo  = e[31:0];
    check("ign_done_busy", {31'b0, busy}, 32'd0);
    check_regs("ign_done");
    tick();
    check("ign_stays_idle", {31'b0, busy}, 32'd0);

    // Start on the retiring edge: retire only, accept on the following edge
    e = ref_op(3'd1, 32'h0000FFFF, 32'h0000FFFF, m_hi, m_lo);
    issue(3'd1, 32'h0000FFFF, 32'h0000FFFF);
    for (int j = 1; j < MC; j++) begin
      check($sformatf("exp_busy_c%0d", j), {31'b0, busy}, 32'd1);
      tick();
    end
    start   = 1'b1;
    md_op   = 3'd4;
    rs_data = 32'hCAFEF00D;
    check("exp_last_busy", {31'b0, busy}, 32'd1);
    tick();
    m_hi = e[63:32];
    m_lo = e[31:0];
    check("exp_retire_busy", {31'b0, busy}, 32'd0);
    check("exp_retire_hi", hi, m_hi);
    check("exp_retire_lo", lo, m_lo);
    tick();
    start = 1'b0;
    m_hi  = 32'hCAFEF00D;
    check("exp_accept_busy", {31'b0, busy}, 32'd0);
    check_regs("exp_accept");

    // Reset in the third busy cycle discards the pending result
    issue(3'd0, 32'h00000007, 32'h00000009);
    check("rst_busy_c1", {31'b0, busy}, 32'd1);
    tick();
    check("rst_busy_c2", {31'b0, busy}, 32'd1);
    tick();
    check("rst_busy_c3", {31'b0, busy}, 32'd1);
    do_reset();
    check("rst_after_busy", {31'b0, busy}, 32'd0);
    check_regs("rst_after");
    repeat (5) tick();
    check("rst_later_busy", {31'b0, busy}, 32'd0);
    check_regs("rst_later");

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 17));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      if (op < 3'd4) run_md($sformatf("rnd%0d_op%0d", i, op), op, a, b);
      else           run_mt($sformatf("rnd%0d_op%0d", i, op), op, a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
